// File: rtl/dfp_pkg.sv
// rtl/dfp_pkg.sv - shared encodings, command codes and frame helpers for the DFPlayer controller
package dfp_pkg;

    // game_state encodings produced by the game FSM
    localparam logic [3:0] GS_BEGINNING = 4'd0;
    localparam logic [3:0] GS_INGAME    = 4'd1;
    localparam logic [3:0] GS_HALT      = 4'd2;
    localparam logic [3:0] GS_ENDING    = 4'd3;

    // DFPlayer command codes
    localparam logic [7:0] CMD_VOL    = 8'h06;
    localparam logic [7:0] CMD_PLAY   = 8'h03;
    localparam logic [7:0] CMD_PAUSE  = 8'h0E;
    localparam logic [7:0] CMD_RESUME = 8'h0D;
    localparam logic [7:0] CMD_STOP   = 8'h16;

    // Fixed frame bytes: start, version, length, no-feedback, end
    localparam logic [7:0] FR_START = 8'h7E;
    localparam logic [7:0] FR_VER   = 8'hFF;
    localparam logic [7:0] FR_LEN   = 8'h06;
    localparam logic [7:0] FR_NOFB  = 8'h00;
    localparam logic [7:0] FR_END   = 8'hEF;

    localparam logic [3:0] LAST_BYTE = 4'd9;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } dfp_state_e;

    // Two's-complement of the byte sum from version through param low, 16-bit wrap
    function automatic logic [15:0] dfp_checksum(input logic [7:0] cmd, input logic [15:0] param);
        logic [15:0] sum;
        sum = 16'(FR_VER) + 16'(FR_LEN) + 16'(cmd) + 16'(FR_NOFB)
            + 16'(param[15:8]) + 16'(param[7:0]);
        return 16'h0000 - sum;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 single-byte UART transmitter
//
// Ports:
//   clk, reset (async, active-low)
//   start      : load data and begin the start bit next cycle (wins over finishing)
//   data[7:0]  : byte to send, LSB first
//   txd        : registered serial output, idle high
//   done       : high on the last cycle of the stop bit
module uart_tx_byte #(
    parameter int BIT_DIV = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int DW = $clog2(BIT_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          active_q, active_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end = active_q && (div_q == DIV_LAST);
    assign done    = bit_end && (bit_q == 4'd9);
    assign txd     = txd_q;

    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        active_d = active_q;
        txd_d    = txd_q;
        if (start) begin
            // Start bit goes straight onto the line; data plus stop bit wait in the shifter
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = 4'd0;
            txd_d    = 1'b0;
            shift_d  = {1'b1, data};
        end else if (active_q) begin
            if (bit_end) begin
                div_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '1;
            active_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: rtl/dfplayer_ctrl.sv
// rtl/dfplayer_ctrl.sv - turns game-state transitions into DFPlayer Mini UART command frames
//
// Ports:
//   clk, reset (async, active-low)
//   game_state[3:0] : 0 beginning, 1 ingame, 2 halt, 3 ending
//   choice[1:0]     : song select, captured with the beginning->ingame edge
//   uart_txd        : serial command stream, idle high
//   busy            : start bit of a frame through end of the post-frame gap
//   cmd_done        : one-cycle pulse when the gap ends
module dfplayer_ctrl
    import dfp_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int VOLUME     = 20,
    parameter int INIT_DELAY = 200_000_000,
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] game_state,
    input  logic [1:0] choice,
    output logic       uart_txd,
    output logic       busy,
    output logic       cmd_done
);

    localparam int          BIT_DIV   = CLK_HZ / BAUD;
    localparam logic [31:0] INIT_LAST = 32'(INIT_DELAY - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [15:0] VOL_PARAM = 16'(VOLUME);

    dfp_state_e  state_q, state_d;
    logic [3:0]  prev_q, prev_d;
    logic        slot_vld_q, slot_vld_d;
    logic [7:0]  slot_cmd_q, slot_cmd_d;
    logic [15:0] slot_par_q, slot_par_d;
    logic        vol_pend_q, vol_pend_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] par_q, par_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] init_cnt_q, init_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        busy_q, busy_d;
    logic        cmd_done_q, cmd_done_d;

    logic        ev_vld;
    logic [7:0]  ev_cmd;
    logic [15:0] ev_par;
    logic [15:0] ck;
    logic [3:0]  sel;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;

    assign prev_d   = game_state;
    assign ck       = dfp_checksum(cmd_q, par_q);
    assign busy     = busy_q;
    assign cmd_done = cmd_done_q;

    // Transition decode against last cycle's state
    always_comb begin
        ev_vld = 1'b0;
        ev_cmd = CMD_STOP;
        ev_par = 16'h0000;
        if (prev_q == GS_BEGINNING && game_state == GS_INGAME) begin
            ev_vld = 1'b1;
            ev_cmd = CMD_PLAY;
            ev_par = 16'(choice) + 16'd1;
        end else if (prev_q == GS_INGAME && game_state == GS_HALT) begin
            ev_vld = 1'b1;
            ev_cmd = CMD_PAUSE;
        end else if (prev_q == GS_HALT && game_state == GS_INGAME) begin
            ev_vld = 1'b1;
            ev_cmd = CMD_RESUME;
        end else if ((game_state == GS_ENDING && prev_q != GS_ENDING) ||
                     (game_state == GS_BEGINNING && prev_q != GS_BEGINNING)) begin
            ev_vld = 1'b1;
            ev_cmd = CMD_STOP;
        end
    end

    // Byte 0 is handed over during LOAD; later bytes are requested one ahead of idx_q
    assign sel      = (state_q == ST_LOAD) ? 4'd0 : idx_q + 4'd1;
    assign tx_start = (state_q == ST_LOAD) ||
                      (state_q == ST_SEND && tx_done && idx_q != LAST_BYTE);

    always_comb begin
        tx_data = FR_END;
        case (sel)
            4'd0:    tx_data = FR_START;
            4'd1:    tx_data = FR_VER;
            4'd2:    tx_data = FR_LEN;
            4'd3:    tx_data = cmd_q;
            4'd4:    tx_data = FR_NOFB;
            4'd5:    tx_data = par_q[15:8];
            4'd6:    tx_data = par_q[7:0];
            4'd7:    tx_data = ck[15:8];
            4'd8:    tx_data = ck[7:0];
            default: tx_data = FR_END;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        slot_vld_d = slot_vld_q;
        slot_cmd_d = slot_cmd_q;
        slot_par_d = slot_par_q;
        vol_pend_d = vol_pend_q;
        cmd_d      = cmd_q;
        par_d      = par_q;
        idx_d      = idx_q;
        init_cnt_d = init_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        cmd_done_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) state_d = ST_IDLE;
                else                         init_cnt_d = init_cnt_q + 32'd1;
            end
            ST_IDLE: begin
                if (vol_pend_q || slot_vld_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // The power-up volume command goes ahead of anything queued during INIT
                if (vol_pend_q) begin
                    cmd_d      = CMD_VOL;
                    par_d      = VOL_PARAM;
                    vol_pend_d = 1'b0;
                end else begin
                    cmd_d      = slot_cmd_q;
                    par_d      = slot_par_q;
                    slot_vld_d = 1'b0;
                end
                idx_d   = 4'd0;
                busy_d  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 32'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    cmd_done_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // A fresh event always lands in the slot, even over a LOAD-cycle clear
        if (ev_vld) begin
            slot_vld_d = 1'b1;
            slot_cmd_d = ev_cmd;
            slot_par_d = ev_par;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            prev_q     <= GS_BEGINNING;
            slot_vld_q <= 1'b0;
            slot_cmd_q <= 8'h00;
            slot_par_q <= 16'h0000;
            vol_pend_q <= 1'b1;
            cmd_q      <= 8'h00;
            par_q      <= 16'h0000;
            idx_q      <= 4'd0;
            init_cnt_q <= 32'd0;
            gap_cnt_q  <= 32'd0;
            busy_q     <= 1'b0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            slot_vld_q <= slot_vld_d;
            slot_cmd_q <= slot_cmd_d;
            slot_par_q <= slot_par_d;
            vol_pend_q <= vol_pend_d;
            cmd_q      <= cmd_d;
            par_q      <= par_d;
            idx_q      <= idx_d;
            init_cnt_q <= init_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    uart_tx_byte #(
        .BIT_DIV (BIT_DIV)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (tx_data),
        .txd   (uart_txd),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_dfplayer_ctrl.sv
// tb/tb_dfplayer_ctrl.sv - directed self-checking bench for dfplayer_ctrl
module tb_dfplayer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] game_state = 4'd0;
    logic [1:0] choice = 2'd0;
    logic       uart_txd;
    logic       busy;
    logic       cmd_done;

    int vec  = 0;
    int errs = 0;

    logic [79:0] rx_got;
    bit          rx_ok;

    localparam logic [79:0] F_VOL    = 80'h7EFF0606000014FEE1EF;
    localparam logic [79:0] F_PLAY2  = 80'h7EFF0603000002FEF6EF;
    localparam logic [79:0] F_PLAY4  = 80'h7EFF0603000004FEF4EF;
    localparam logic [79:0] F_PAUSE  = 80'h7EFF060E000000FEEDEF;
    localparam logic [79:0] F_RESUME = 80'h7EFF060D000000FEEEEF;
    localparam logic [79:0] F_STOP   = 80'h7EFF0616000000FEE5EF;

    always #5 clk = ~clk;

    dfplayer_ctrl #(
        .CLK_HZ     (76800),
        .BAUD       (9600),
        .VOLUME     (20),
        .INIT_DELAY (50),
        .GAP_CYCLES (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_state (game_state),
        .choice     (choice),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .cmd_done   (cmd_done)
    );

    // Negedges counted until the line goes low; -1 when the budget runs out
    task automatic wait_start(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_txd !== 1'b0 && n < budget);
        if (uart_txd !== 1'b0) n = -1;
    endtask

    // Decode one byte; det=1 means the current negedge is the first start-bit cycle
    task automatic rx_byte(input int tmo, input bit det, output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1;
        b  = 8'h00;
        if (!det) begin
            wait_start(tmo, n);
            if (n < 0) begin
                ok = 1'b0;
                return;
            end
        end
        repeat (4) @(negedge clk);
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = uart_txd;
        end
        repeat (8) @(negedge clk);
        if (uart_txd !== 1'b1) ok = 1'b0;
    endtask

    // Ten bytes, each start bit required within 4 cycles of the previous stop-bit centre
    task automatic rx_frame();
        logic [7:0] b;
        bit         ok;
        rx_ok  = 1'b1;
        rx_got = '0;
        for (int k = 0; k < 10; k++) begin
            rx_byte(4, (k == 0), b, ok);
            if (!ok) rx_ok = 1'b0;
            rx_got = {rx_got[71:0], b};
        end
    endtask

    // From the last stop-bit centre: negedge index of cmd_done, line-high flag, busy there
    task automatic gap_watch(output int pos, output bit hi, output logic bsy);
        pos = -1;
        hi  = 1'b1;
        bsy = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) hi = 1'b0;
            if (cmd_done === 1'b1) begin
                pos = i;
                bsy = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec++;
        if (uart_txd !== 1'b1) begin errs++; $display("FAIL reset_txd got %b want 1", uart_txd); end
        vec++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++;
        if (cmd_done !== 1'b0) begin errs++; $display("FAIL reset_cmd_done got %b want 0", cmd_done); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_volume();
        int n, pos;
        bit hi;
        logic bsy;
        wait_start(100, n);
        vec++;
        if (n != 53) begin errs++; $display("FAIL vol_latency got %0d want 53", n); end
        rx_frame();
        vec++;
        if (!rx_ok || rx_got !== F_VOL) begin errs++; $display("FAIL vol_frame got %h ok=%0d want %h", rx_got, rx_ok, F_VOL); end
        gap_watch(pos, hi, bsy);
        vec++;
        if (pos != 24 || !hi) begin errs++; $display("FAIL vol_gap got pos=%0d high=%0d want pos=24 high=1", pos, hi); end
        vec++;
        if (bsy !== 1'b0) begin errs++; $display("FAIL vol_busy_at_done got %b want 0", bsy); end
        @(negedge clk);
        vec++;
        if (cmd_done !== 1'b0) begin errs++; $display("FAIL vol_done_once got %b want 0", cmd_done); end
    endtask

    task automatic test_play();
        int n, pos;
        bit hi;
        logic bsy;
        choice = 2'd1;
        @(posedge clk);
        #1 game_state = 4'd1;
        wait_start(20, n);
        vec++;
        if (n != 4) begin errs++; $display("FAIL play_latency got %0d want 4", n); end
        vec++;
        if (busy !== 1'b1) begin errs++; $display("FAIL play_busy got %b want 1", busy); end
        rx_frame();
        vec++;
        if (!rx_ok || rx_got !== F_PLAY2) begin errs++; $display("FAIL play_frame got %h ok=%0d want %h", rx_got, rx_ok, F_PLAY2); end
        gap_watch(pos, hi, bsy);
        vec++;
        if (pos != 24 || !hi || bsy !== 1'b0) begin errs++; $display("FAIL play_gap got pos=%0d high=%0d busy=%b want 24 1 0", pos, hi, bsy); end
    endtask

    task automatic test_pause_resume();
        int n, pos;
        bit hi;
        logic bsy;
        @(posedge clk);
        #1 game_state = 4'd2;
        wait_start(20, n);
        game_state = 4'd1;
        rx_frame();
        vec++;
        if (n != 4 || !rx_ok || rx_got !== F_PAUSE) begin errs++; $display("FAIL pause_frame got %h ok=%0d lat=%0d want %h", rx_got, rx_ok, n, F_PAUSE); end
        gap_watch(pos, hi, bsy);
        vec++;
        if (pos != 24 || !hi) begin errs++; $display("FAIL pause_gap got pos=%0d high=%0d want 24 1", pos, hi); end
        wait_start(40, n);
        vec++;
        if (n != 2) begin errs++; $display("FAIL resume_after_gap got %0d want 2", n); end
        rx_frame();
        vec++;
        if (!rx_ok || rx_got !== F_RESUME) begin errs++; $display("FAIL resume_frame got %h ok=%0d want %h", rx_got, rx_ok, F_RESUME); end
        gap_watch(pos, hi, bsy);
    endtask

    task automatic test_latest_wins();
        int n, pos;
        bit hi, quiet;
        logic bsy;
        @(posedge clk);
        #1 game_state = 4'd0;
        wait_start(20, n);
        rx_frame();
        vec++;
        if (n != 4 || !rx_ok || rx_got !== F_STOP) begin errs++; $display("FAIL stop_to_begin got %h ok=%0d want %h", rx_got, rx_ok, F_STOP); end
        gap_watch(pos, hi, bsy);
        choice = 2'd3;
        @(posedge clk);
        #1 game_state = 4'd1;
        wait_start(20, n);
        fork
            rx_frame();
            begin
                repeat (3) @(negedge clk);
                game_state = 4'd2;
                choice     = 2'd0;
                repeat (2) @(negedge clk);
                game_state = 4'd1;
            end
        join
        vec++;
        if (n != 4 || !rx_ok || rx_got !== F_PLAY4) begin errs++; $display("FAIL play_intact got %h ok=%0d want %h", rx_got, rx_ok, F_PLAY4); end
        gap_watch(pos, hi, bsy);
        wait_start(40, n);
        rx_frame();
        vec++;
        if (n != 2 || !rx_ok || rx_got !== F_RESUME) begin errs++; $display("FAIL latest_resume got %h ok=%0d lat=%0d want %h", rx_got, rx_ok, n, F_RESUME); end
        gap_watch(pos, hi, bsy);
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) quiet = 1'b0;
        end
        vec++;
        if (!quiet) begin errs++; $display("FAIL no_pause_after got quiet=%0d want 1", quiet); end
    endtask

    task automatic test_stop_quiet();
        int n, pos;
        bit hi, quiet;
        logic bsy;
        @(posedge clk);
        #1 game_state = 4'd3;
        wait_start(20, n);
        rx_frame();
        vec++;
        if (n != 4 || !rx_ok || rx_got !== F_STOP) begin errs++; $display("FAIL stop_frame got %h ok=%0d want %h", rx_got, rx_ok, F_STOP); end
        gap_watch(pos, hi, bsy);
        vec++;
        if (pos != 24) begin errs++; $display("FAIL stop_gap got pos=%0d want 24", pos); end
        quiet = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        vec++;
        if (!quiet) begin errs++; $display("FAIL ending_quiet got quiet=%0d want 1", quiet); end
    endtask

    task automatic test_reset_midframe();
        int n, pos;
        bit hi, ok, all_ok;
        logic bsy;
        logic [7:0] b;
        @(posedge clk);
        #1 game_state = 4'd0;
        wait_start(20, n);
        all_ok = (n == 4);
        for (int k = 0; k < 4; k++) begin
            rx_byte(4, (k == 0), b, ok);
            if (!ok) all_ok = 1'b0;
        end
        wait_start(4, n);
        if (n < 0) all_ok = 1'b0;
        repeat (20) @(negedge clk);
        vec++;
        if (!all_ok || uart_txd !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL midframe_pre got txd=%b busy=%b ok=%0d want 0 1 1", uart_txd, busy, all_ok);
        end
        #1 reset = 1'b0;
        #1;
        vec++;
        if (uart_txd !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL midframe_reset got txd=%b busy=%b want 1 0", uart_txd, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        wait_start(100, n);
        vec++;
        if (n != 53) begin errs++; $display("FAIL reinit_latency got %0d want 53", n); end
        rx_frame();
        vec++;
        if (!rx_ok || rx_got !== F_VOL) begin errs++; $display("FAIL reinit_vol got %h ok=%0d want %h", rx_got, rx_ok, F_VOL); end
        gap_watch(pos, hi, bsy);
        vec++;
        if (pos != 24 || bsy !== 1'b0) begin errs++; $display("FAIL reinit_gap got pos=%0d busy=%b want 24 0", pos, bsy); end
    endtask

    initial begin
        test_reset();
        test_volume();
        test_play();
        test_pause_resume();
        test_latest_wins();
        test_stop_quiet();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
